// File: rtl/instr_fetch_mem.sv
// Instruction memory with a built-in fetch sequencer: program load while idle,
// {pc, instr} streamed over valid/ready, HALT sentinel detection and branch redirect.
module instr_fetch_mem #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 6,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'hFFFF_FFFF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [ADDR_W-1:0] halt_pc,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              out_valid_n;
  logic [DATA_W-1:0] out_instr_n;
  logic [ADDR_W-1:0] out_pc_n;
  logic              halted_n;
  logic [ADDR_W-1:0] halt_pc_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              advance;

  // NOTE: the memory array has no reset branch; the program image must survive rst.
  always_ff @(posedge clk) begin
    if (ld_en && state != S_RUN) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign rd_word = mem[pc];
  assign advance = !out_valid || out_ready;
  assign busy    = (state == S_RUN);

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    out_valid_n = out_valid;
    out_instr_n = out_instr;
    out_pc_n    = out_pc;
    halted_n    = halted;
    halt_pc_n   = halt_pc;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = '0;
        end
      end

      S_RUN: begin
        // A redirect flushes whatever sits in the output register, accepted or not.
        if (redirect_valid) begin
          pc_n        = redirect_addr;
          out_valid_n = 1'b0;
        end else if (advance) begin
          if (rd_word == HALT_WORD) begin
            out_valid_n = 1'b0;
            halted_n    = 1'b1;
            halt_pc_n   = pc;
            state_n     = S_HALT;
          end else begin
            out_instr_n = rd_word;
            out_pc_n    = pc;
            out_valid_n = 1'b1;
            pc_n        = pc + ADDR_W'(1);
          end
        end
      end

      S_HALT: begin
        if (redirect_valid) begin
          state_n  = S_RUN;
          pc_n     = redirect_addr;
          halted_n = 1'b0;
        end else if (start) begin
          state_n  = S_RUN;
          pc_n     = '0;
          halted_n = 1'b0;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
      halt_pc   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      out_valid <= out_valid_n;
      out_instr <= out_instr_n;
      out_pc    <= out_pc_n;
      halted    <= halted_n;
      halt_pc   <= halt_pc_n;
    end
  end

endmodule
